// File: rtl/mat_transpose.sv
// Registered matrix transpose: captures an M x N matrix on in_valid and
// presents its N x M transpose one cycle later, with a matching valid pulse.
// Elements are opaque bit patterns; nothing is interpreted or modified.
`timescale 1ns/1ps
module mat_transpose #(
    parameter int unsigned M      = 2,
    parameter int unsigned N      = 3,
    parameter int unsigned DATA_W = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    input  logic [M-1:0][N-1:0][DATA_W-1:0]     input_mat,
    output logic                                out_valid,
    output logic [N-1:0][M-1:0][DATA_W-1:0]     output_mat_transposed
);

    logic [N-1:0][M-1:0][DATA_W-1:0] mat_d, mat_q;
    logic                            valid_q;

    // Pure index swap of the incoming matrix; no logic on the data bits.
    always_comb begin
        mat_d = '0;
        for (int unsigned i = 0; i < M; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
                mat_d[j][i] = input_mat[i][j];
            end
        end
    end

    // Result register: reset wins over a capture on the same edge, otherwise hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mat_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                mat_q <= mat_d;
            end
        end
    end

    // Outputs come straight from flops, so there is no input-to-output path.
    always_comb begin
        out_valid             = valid_q;
        output_mat_transposed = mat_q;
    end

endmodule

// File: tb/tb_mat_transpose.sv
// Bench for mat_transpose: four shapes (2x3, 3x3, 1x4, 4x1) share one clock,
// reset and valid. A single reference matrix feeds each DUT its top-left
// sub-block; the model remembers the last captured matrix and expects
// out[j][i] == captured[i][j] one cycle later.
`timescale 1ns/1ps
module tb_mat_transpose;

    logic clk;
    logic rst;
    logic vld;

    logic [1:0][2:0][31:0] in23;
    logic [2:0][1:0][31:0] out23;
    logic                  ov23;
    logic [2:0][2:0][31:0] in33;
    logic [2:0][2:0][31:0] out33;
    logic                  ov33;
    logic [0:0][3:0][31:0] in14;
    logic [3:0][0:0][31:0] out14;
    logic                  ov14;
    logic [3:0][0:0][31:0] in41;
    logic [0:0][3:0][31:0] out41;
    logic                  ov41;

    // Reference state: source matrix, last captured matrix, expected valid.
    logic [31:0] a [4][4];
    logic [31:0] e [4][4];
    logic        ev;

    int total;
    int bad;

    logic [191:0] lit_in;
    logic [191:0] lit_out;
    logic [127:0] vec;

    mat_transpose #(.M(2), .N(3), .DATA_W(32)) u_23 (
        .clk(clk), .rst(rst), .in_valid(vld), .input_mat(in23),
        .out_valid(ov23), .output_mat_transposed(out23)
    );
    mat_transpose #(.M(3), .N(3), .DATA_W(32)) u_33 (
        .clk(clk), .rst(rst), .in_valid(vld), .input_mat(in33),
        .out_valid(ov33), .output_mat_transposed(out33)
    );
    mat_transpose #(.M(1), .N(4), .DATA_W(32)) u_14 (
        .clk(clk), .rst(rst), .in_valid(vld), .input_mat(in14),
        .out_valid(ov14), .output_mat_transposed(out14)
    );
    mat_transpose #(.M(4), .N(1), .DATA_W(32)) u_41 (
        .clk(clk), .rst(rst), .in_valid(vld), .input_mat(in41),
        .out_valid(ov41), .output_mat_transposed(out41)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rand_a();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                a[i][j] = $urandom;
    endtask

    // Present a[][] to every DUT, take one clock edge, advance the model, settle.
    task automatic step();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (i < 2 && j < 3) in23[i][j] = a[i][j];
                if (i < 3 && j < 3) in33[i][j] = a[i][j];
                if (i < 1) in14[i][j] = a[i][j];
                if (j < 1) in41[i][j] = a[i][j];
            end
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    e[i][j] = '0;
            ev = 1'b0;
        end else if (vld) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    e[i][j] = a[i][j];
            ev = 1'b1;
        end else begin
            ev = 1'b0;
        end
        #1;
    endtask

    task automatic chk(input string tag);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (i < 2 && j < 3) cmp({tag, "/23"}, out23[j][i], e[i][j]);
                if (i < 3 && j < 3) cmp({tag, "/33"}, out33[j][i], e[i][j]);
                if (i < 1) cmp({tag, "/14"}, out14[j][i], e[i][j]);
                if (j < 1) cmp({tag, "/41"}, out41[j][i], e[i][j]);
            end
        end
        cmp({tag, "/v23"}, {31'b0, ov23}, {31'b0, ev});
        cmp({tag, "/v33"}, {31'b0, ov33}, {31'b0, ev});
        cmp({tag, "/v14"}, {31'b0, ov14}, {31'b0, ev});
        cmp({tag, "/v41"}, {31'b0, ov41}, {31'b0, ev});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        ev    = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                e[i][j] = '0;

        // Reset with valid data present: data discarded, outputs zero.
        rst = 1'b1;
        vld = 1'b1;
        rand_a();
        step();
        step();
        chk("reset");

        // Known float matrix, concatenation order MSB-first = highest index.
        rst     = 1'b0;
        lit_in  = 192'h3F800000_40000000_40400000_40800000_40A00000_40C00000;
        lit_out = 192'h3F800000_40800000_40000000_40A00000_40400000_40C00000;
        rand_a();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 3; j++)
                a[i][j] = lit_in[(i * 3 + j) * 32 +: 32];
        step();
        chk("float");
        cmp("float_flat_hi", out23[2], lit_out[191:128]);
        cmp("float_flat_mid", out23[1], lit_out[127:64]);
        cmp("float_flat_lo", out23[0], lit_out[63:0]);

        // Idle with junk on the input: output holds, valid drops.
        vld = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                a[i][j] = 32'hFFFFFFFF;
        step();
        chk("hold");
        cmp("hold_flat_hi", out23[2], lit_out[191:128]);
        cmp("hold_flat_lo", out23[0], lit_out[63:0]);

        // Three back-to-back matrices.
        vld = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rand_a();
            step();
            chk("stream");
        end
        vld = 1'b0;
        step();
        chk("stream_end");

        // Mid-stream reset drops the in-flight result; next capture is normal.
        vld = 1'b1;
        rand_a();
        step();
        chk("pre_rst");
        rst = 1'b1;
        rand_a();
        step();
        chk("mid_rst");
        rst = 1'b0;
        rand_a();
        step();
        chk("post_rst");

        // 3x3 with element value i*N+j; diagonal must be unchanged.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                a[i][j] = 32'(i * 3 + j);
        step();
        chk("idx33");
        for (int d = 0; d < 3; d++) cmp("diag33", out33[d][d], 32'(d * 4));

        // Row vector: transposed packed layout keeps the same bit pattern.
        rand_a();
        a[0][3] = 32'hAAAAAAAA;
        a[0][2] = 32'hBBBBBBBB;
        a[0][1] = 32'hCCCCCCCC;
        a[0][0] = 32'hDDDDDDDD;
        step();
        chk("vec14");
        vec = out14;
        cmp("vec14_flat_hi", vec[127:96], 32'hAAAAAAAA);
        cmp("vec14_flat_lo", vec[31:0], 32'hDDDDDDDD);
        vec = out41;
        cmp("vec41_flat", vec[63:32], a[1][0]);

        // Random traffic with sporadic resets.
        for (int k = 0; k < 40; k++) begin
            rst = ($urandom_range(0, 9) == 0);
            vld = 1'($urandom_range(0, 1));
            rand_a();
            step();
            chk("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
